// File: rtl/mac_tile_scheduler.sv
// rtl/mac_tile_scheduler.sv - output-tile sequencer for the 16-lane MAC array and accumulator collector
//
// Accepts one tile command, issues operand-buffer reads for k_len accumulation
// passes of ROWS collector entries (plus an optional VSQ scale pass), aligns the
// MAC valid/mode strobes with the buffer read latency, then requests and tracks
// the collector PPU readout.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_mode, cmd_k_len, cmd_vsq_en command fields
//   hold                           buffer backpressure, stalls read issue
//   a_rd_en/a_rd_addr              weight buffer read (block index k)
//   b_rd_en/b_rd_addr              activation buffer read (k*16+row)
//   s_rd_en/s_rd_addr              scale-factor read during the VSQ pass
//   mac_valid, is_int8_mode, is_int4_mode, is_vsq   MAC strobes
//   acc_start, acc_mac_done, acc_ppu                collector controls
//   ppu_out_valid, ppu_row                          collector readout tracking
//   busy, done, err                                 status

module mac_tile_scheduler #(
  parameter int K_MAX  = 32,
  parameter int RD_LAT = 1,
  parameter int ROWS   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [5:0] cmd_k_len,
  input  logic       cmd_vsq_en,
  input  logic       hold,
  output logic       a_rd_en,
  output logic [4:0] a_rd_addr,
  output logic       b_rd_en,
  output logic [8:0] b_rd_addr,
  output logic       s_rd_en,
  output logic [3:0] s_rd_addr,
  output logic       mac_valid,
  output logic       is_int8_mode,
  output logic       is_int4_mode,
  output logic       is_vsq,
  output logic       acc_start,
  output logic       acc_mac_done,
  output logic       acc_ppu,
  output logic       ppu_out_valid,
  output logic [3:0] ppu_row,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ACCUM, S_VSQ, S_FLUSH, S_PPU_REQ, S_PPU_DRAIN, S_DONE
  } state_t;

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [6:0] KMAX_W   = 7'(K_MAX);
  // Every delay-line stage except the output stage; when these are empty the
  // line is empty from the next cycle on.
  localparam logic [RD_LAT-1:0] PRE_MASK = {RD_LAT{1'b1}} >> 1;

  state_t      state_q;
  logic [5:0]  k_q;
  logic [3:0]  row_q;
  logic [5:0]  k_len_q;
  logic        int4_q;
  logic        vsq_en_q;
  logic        acc_start_q;
  logic        acc_ppu_q;
  logic        ppu_valid_q;
  logic [3:0]  ppu_row_q;
  logic        done_q;
  logic        err_q;

  logic [RD_LAT-1:0] dl_vld_q;
  logic [RD_LAT-1:0] dl_vsq_q;
  logic              dl_in_vld_d;
  logic              dl_in_vsq_d;
  logic              dl_drained;
  logic              cmd_illegal;

  assign cmd_illegal = (cmd_k_len == 6'd0) || ({1'b0, cmd_k_len} > KMAX_W) || cmd_mode[1];

  // Reads are issued straight from the state and counters so hold takes
  // effect in the same cycle it is raised.
  assign a_rd_en   = (state_q == S_ACCUM) & ~hold;
  assign b_rd_en   = (state_q == S_ACCUM) & ~hold;
  assign s_rd_en   = (state_q == S_VSQ) & ~hold;
  assign a_rd_addr = k_q[4:0];
  assign b_rd_addr = {k_q[4:0], row_q};
  assign s_rd_addr = row_q;

  assign dl_in_vld_d = a_rd_en | s_rd_en;
  assign dl_in_vsq_d = s_rd_en;
  assign dl_drained  = ~|(dl_vld_q & PRE_MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      row_q       <= '0;
      k_len_q     <= '0;
      int4_q      <= 1'b0;
      vsq_en_q    <= 1'b0;
      acc_start_q <= 1'b0;
      acc_ppu_q   <= 1'b0;
      ppu_valid_q <= 1'b0;
      ppu_row_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      acc_start_q <= 1'b0;
      acc_ppu_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            k_len_q  <= cmd_k_len;
            int4_q   <= cmd_mode[0];
            vsq_en_q <= cmd_vsq_en;
            if (cmd_illegal) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= S_START;
              acc_start_q <= 1'b1;
            end
          end
        end
        S_START: begin
          state_q <= S_ACCUM;
          k_q     <= '0;
          row_q   <= '0;
        end
        S_ACCUM: begin
          if (!hold) begin
            row_q <= row_q + 4'd1;
            if (row_q == LAST_ROW) begin
              if (k_q == k_len_q - 6'd1) begin
                k_q     <= '0;
                state_q <= vsq_en_q ? S_VSQ : S_FLUSH;
              end else begin
                k_q <= k_q + 6'd1;
              end
            end
          end
        end
        S_VSQ: begin
          if (!hold) begin
            row_q <= row_q + 4'd1;
            if (row_q == LAST_ROW) state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // Leaving only once the last issue is at the output stage keeps
          // acc_ppu strictly after the final acc_mac_done.
          if (dl_drained) begin
            state_q   <= S_PPU_REQ;
            acc_ppu_q <= 1'b1;
          end
        end
        S_PPU_REQ: begin
          state_q     <= S_PPU_DRAIN;
          ppu_valid_q <= 1'b1;
          ppu_row_q   <= '0;
        end
        S_PPU_DRAIN: begin
          if (ppu_row_q == LAST_ROW) begin
            state_q     <= S_DONE;
            ppu_valid_q <= 1'b0;
            ppu_row_q   <= '0;
            done_q      <= 1'b1;
          end else begin
            ppu_row_q <= ppu_row_q + 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Issue-to-MAC delay line; it keeps shifting through hold so in-flight
  // operands still reach the MAC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld_q <= '0;
      dl_vsq_q <= '0;
    end else begin
      dl_vld_q[0] <= dl_in_vld_d;
      dl_vsq_q[0] <= dl_in_vsq_d;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_vsq_q[i] <= dl_vsq_q[i-1];
      end
    end
  end

  assign mac_valid    = dl_vld_q[RD_LAT-1];
  assign acc_mac_done = dl_vld_q[RD_LAT-1];
  assign is_vsq       = dl_vld_q[RD_LAT-1] & dl_vsq_q[RD_LAT-1];
  assign is_int8_mode = dl_vld_q[RD_LAT-1] & ~dl_vsq_q[RD_LAT-1] & ~int4_q;
  assign is_int4_mode = dl_vld_q[RD_LAT-1] & ~dl_vsq_q[RD_LAT-1] & int4_q;

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign acc_start     = acc_start_q;
  assign acc_ppu       = acc_ppu_q;
  assign ppu_out_valid = ppu_valid_q;
  assign ppu_row       = ppu_row_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mac_tile_scheduler.sv
// tb/tb_mac_tile_scheduler.sv - scoreboard bench for mac_tile_scheduler
module tb_mac_tile_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cmd_valid1, cmd_valid3;
  logic [1:0] cmd_mode;
  logic [5:0] cmd_k_len;
  logic       cmd_vsq_en;
  logic       hold;

  typedef struct packed {
    logic       cmd_ready;
    logic       a_rd_en;
    logic [4:0] a_rd_addr;
    logic       b_rd_en;
    logic [8:0] b_rd_addr;
    logic       s_rd_en;
    logic [3:0] s_rd_addr;
    logic       mac_valid;
    logic       is_int8;
    logic       is_int4;
    logic       is_vsq;
    logic       acc_start;
    logic       acc_mac_done;
    logic       acc_ppu;
    logic       ppu_out_valid;
    logic [3:0] ppu_row;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  wire obs_t o1;
  wire obs_t o3;
  obs_t m;
  logic sel;
  assign m = sel ? o3 : o1;

  mac_tile_scheduler #(.K_MAX(32), .RD_LAT(1), .ROWS(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(o1.cmd_ready),
    .cmd_mode(cmd_mode), .cmd_k_len(cmd_k_len), .cmd_vsq_en(cmd_vsq_en), .hold(hold),
    .a_rd_en(o1.a_rd_en), .a_rd_addr(o1.a_rd_addr), .b_rd_en(o1.b_rd_en), .b_rd_addr(o1.b_rd_addr),
    .s_rd_en(o1.s_rd_en), .s_rd_addr(o1.s_rd_addr), .mac_valid(o1.mac_valid),
    .is_int8_mode(o1.is_int8), .is_int4_mode(o1.is_int4), .is_vsq(o1.is_vsq),
    .acc_start(o1.acc_start), .acc_mac_done(o1.acc_mac_done), .acc_ppu(o1.acc_ppu),
    .ppu_out_valid(o1.ppu_out_valid), .ppu_row(o1.ppu_row), .busy(o1.busy),
    .done(o1.done), .err(o1.err)
  );

  mac_tile_scheduler #(.K_MAX(32), .RD_LAT(3), .ROWS(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(o3.cmd_ready),
    .cmd_mode(cmd_mode), .cmd_k_len(cmd_k_len), .cmd_vsq_en(cmd_vsq_en), .hold(hold),
    .a_rd_en(o3.a_rd_en), .a_rd_addr(o3.a_rd_addr), .b_rd_en(o3.b_rd_en), .b_rd_addr(o3.b_rd_addr),
    .s_rd_en(o3.s_rd_en), .s_rd_addr(o3.s_rd_addr), .mac_valid(o3.mac_valid),
    .is_int8_mode(o3.is_int8), .is_int4_mode(o3.is_int4), .is_vsq(o3.is_vsq),
    .acc_start(o3.acc_start), .acc_mac_done(o3.acc_mac_done), .acc_ppu(o3.acc_ppu),
    .ppu_out_valid(o3.ppu_out_valid), .ppu_row(o3.ppu_row), .busy(o3.busy),
    .done(o3.done), .err(o3.err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       s;
    logic [4:0] a;
    logic [8:0] b;
    logic [3:0] r;
  } rd_t;

  rd_t        exp_rd[$];
  logic [2:0] exp_mode[$];
  logic [3:0] exp_ppu[$];

  int lat, cyc, exp_lat, done_cyc, ppu_cyc;
  int n_start, n_ppu, n_done;
  int bad_lag, bad_mode, bad_hold, bad_overlap, bad_busy;
  logic [7:0] hist;

  // Monitor one cycle at the falling edge, then step to just after the next rising edge.
  task automatic sample();
    rd_t e;
    logic [2:0] em;
    logic [3:0] er;
    @(negedge clk);
    if (m.a_rd_en || m.b_rd_en || m.s_rd_en) begin
      if (hold) bad_hold++;
      if (exp_rd.size() == 0) begin
        check("rd_extra", 1, 0);
      end else begin
        e = exp_rd.pop_front();
        check("rd_kind", {m.a_rd_en, m.b_rd_en, m.s_rd_en}, e.s ? 3'b001 : 3'b110);
        if (e.s) begin
          check("s_addr", m.s_rd_addr, e.r);
        end else begin
          check("a_addr", m.a_rd_addr, e.a);
          check("b_addr", m.b_rd_addr, e.b);
        end
      end
    end
    if (m.mac_valid !== hist[lat-1]) bad_lag++;
    if (m.acc_mac_done !== m.mac_valid) bad_lag++;
    hist = {hist[6:0], m.a_rd_en | m.s_rd_en};
    if (m.mac_valid) begin
      if (exp_mode.size() == 0) begin
        check("mac_extra", 1, 0);
      end else begin
        em = exp_mode.pop_front();
        check("mac_mode", {m.is_int8, m.is_int4, m.is_vsq}, em);
      end
    end else if (m.is_int8 || m.is_int4 || m.is_vsq) begin
      bad_mode++;
    end
    if (m.acc_start) n_start++;
    if (m.acc_ppu) begin
      n_ppu++;
      ppu_cyc = cyc;
      if (m.acc_mac_done) bad_overlap++;
    end
    if (m.ppu_out_valid) begin
      if (exp_ppu.size() == 0) begin
        check("ppu_extra", 1, 0);
      end else begin
        er = exp_ppu.pop_front();
        check("ppu_row", m.ppu_row, er);
      end
    end
    if (m.done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (m.busy === m.cmd_ready) bad_busy++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_mon();
    exp_rd.delete();
    exp_mode.delete();
    exp_ppu.delete();
    hist = '0;
    n_start = 0; n_ppu = 0; n_done = 0;
    bad_lag = 0; bad_mode = 0; bad_hold = 0; bad_overlap = 0; bad_busy = 0;
    done_cyc = -1; ppu_cyc = -1;
  endtask

  task automatic send(input bit use3, input logic [1:0] mode, input int k, input bit vsq, input int hold_len);
    rd_t e;
    sel = use3;
    lat = use3 ? 3 : 1;
    clear_mon();
    for (int kk = 0; kk < k; kk++) begin
      for (int r = 0; r < 16; r++) begin
        e.s = 1'b0; e.a = 5'(kk); e.b = 9'(kk * 16 + r); e.r = 4'(r);
        exp_rd.push_back(e);
        exp_mode.push_back(mode[0] ? 3'b010 : 3'b100);
      end
    end
    if (vsq) begin
      for (int r = 0; r < 16; r++) begin
        e.s = 1'b1; e.a = 5'd0; e.b = 9'd0; e.r = 4'(r);
        exp_rd.push_back(e);
        exp_mode.push_back(3'b001);
      end
    end
    for (int r = 0; r < 16; r++) exp_ppu.push_back(4'(r));
    exp_lat = 19 + 16 * k + lat + (vsq ? 16 : 0) + hold_len;
    cmd_mode = mode; cmd_k_len = 6'(k); cmd_vsq_en = vsq;
    if (use3) cmd_valid3 = 1'b1; else cmd_valid1 = 1'b1;
    sample();
    cmd_valid1 = 1'b0; cmd_valid3 = 1'b0;
    cyc = 1;
  endtask

  task automatic finish_tile(input int hold_at, input int hold_len);
    while (n_done == 0 && cyc < 3000) begin
      hold = (cyc >= hold_at) && (cyc < hold_at + hold_len);
      sample();
    end
    hold = 1'b0;
    check("done_seen", n_done, 1);
    check("done_cyc", done_cyc, exp_lat);
    check("ppu_cyc", ppu_cyc, exp_lat - 17);
    check("ready_after", m.cmd_ready, 1);
    check("busy_after", m.busy, 0);
    check("n_start", n_start, 1);
    check("n_ppu", n_ppu, 1);
    check("rd_left", exp_rd.size(), 0);
    check("mac_left", exp_mode.size(), 0);
    check("ppu_left", exp_ppu.size(), 0);
    check("mac_lag", bad_lag, 0);
    check("mode_idle", bad_mode, 0);
    check("rd_in_hold", bad_hold, 0);
    check("ppu_overlap", bad_overlap, 0);
    check("busy_ready", bad_busy, 0);
  endtask

  task automatic illegal(input logic [1:0] mode, input int k);
    sel = 1'b0;
    lat = 1;
    clear_mon();
    cmd_mode = mode; cmd_k_len = 6'(k); cmd_vsq_en = 1'b0;
    cmd_valid1 = 1'b1;
    sample();
    cmd_valid1 = 1'b0;
    cyc = 1;
    check("err_pulse", m.err, 1);
    check("err_busy", m.busy, 0);
    sample();
    check("err_once", m.err, 0);
    sample();
    sample();
    check("err_start", n_start, 0);
    check("err_idle", {m.busy, m.cmd_ready}, 2'b01);
  endtask

  obs_t rv;

  initial begin
    rv = '0;
    rv.cmd_ready = 1'b1;
    sel = 1'b0; lat = 1; cyc = 0; hist = '0;
    rst_n = 1'b0; cmd_valid1 = 1'b0; cmd_valid3 = 1'b0;
    cmd_mode = '0; cmd_k_len = '0; cmd_vsq_en = 1'b0; hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state1", o1, rv);
    check("reset_state3", o3, rv);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic int8 tile, k_len=2
    send(1'b0, 2'b00, 2, 1'b0, 0);
    finish_tile(0, 0);

    // int4 tile with VSQ pass
    send(1'b0, 2'b01, 1, 1'b1, 0);
    finish_tile(0, 0);

    // Backpressure after the third ACCUM issue
    send(1'b0, 2'b00, 1, 1'b0, 5);
    finish_tile(5, 5);

    // Illegal commands, then a legal one
    illegal(2'b00, 0);
    illegal(2'b00, 33);
    illegal(2'b10, 1);
    send(1'b0, 2'b01, 1, 1'b0, 0);
    finish_tile(0, 0);

    // Reset in the middle of ACCUM at k=1,row=7
    send(1'b0, 2'b00, 2, 1'b0, 0);
    while (cyc < 25) sample();
    check("pre_rst_a", m.a_rd_addr, 5'd1);
    check("pre_rst_b", m.b_rd_addr, 9'd23);
    rst_n = 1'b0;
    #1;
    check("rst_async", m, rv);
    clear_mon();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("ready_release", m.cmd_ready, 1);
    send(1'b0, 2'b00, 1, 1'b0, 0);
    finish_tile(0, 0);

    // RD_LAT=3, full-length tile
    send(1'b1, 2'b00, 32, 1'b0, 0);
    finish_tile(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
